traffic_ctrl_nway: RTL and testbench

// Parametrised N-road intersection controller; successor to the fixed 4-road IDLE/NORMAL/JAM controller.

---
 rtl/traffic_ctrl_nway_pkg.sv | 35 +++
 rtl/traffic_ctrl_nway_if.sv | 16 +
 rtl/traffic_ctrl_nway_rr_jam_picker.sv | 31 +++
 rtl/traffic_ctrl_nway.sv | 131 +++++++++++++
 tb/tb_traffic_ctrl_nway.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/traffic_ctrl_nway_pkg.sv
// Shared types for the N-road intersection controller: FSM state codes and round-robin pick helper.
package traffic_pkg;

  localparam int MAX_ROADS = 16;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CLEAR     = 2'd1;
  localparam logic [1:0] GREEN     = 2'd2;
  localparam logic [1:0] JAM_GREEN = 2'd3;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Scan req from ptr+1 round-robin over n roads; ptr itself is visited last and skipped when excl.
  function automatic pick_t rr_pick(input logic [MAX_ROADS-1:0] req,
                                    input logic [3:0] ptr,
                                    input logic excl,
                                    input int unsigned n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 1; k <= MAX_ROADS; k++) begin
      j = {28'd0, ptr} + k;
      if (j >= n) j = j - n;
      if (k <= n && !r.found && !(excl && k == n) && req[j[3:0]]) begin
        r.found = 1'b1;
        r.idx   = j[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/traffic_ctrl_nway_if.sv
// Road-facing bundle: enable and jam sensors in, signal-head drive and status out.
interface traffic_if #(
  parameter int N_ROADS = 4
);
  localparam int IW = $clog2(N_ROADS);

  logic               en;
  logic [N_ROADS-1:0] traffic_jam;
  logic [N_ROADS-1:0] allow;
  logic [IW-1:0]      active_idx;
  logic               jam_mode;
  logic               clearing;

  modport master (output en, traffic_jam, input allow, active_idx, jam_mode, clearing);
  modport slave  (input en, traffic_jam, output allow, active_idx, jam_mode, clearing);
endinterface

// File: rtl/traffic_ctrl_nway_rr_jam_picker.sv
// Combinational round-robin finder: first set req bit after ptr, wrapping, optionally excluding ptr.
module rr_jam_picker
  import traffic_pkg::*;
#(
  parameter int N_ROADS = 4,
  parameter int IW      = $clog2(N_ROADS)
) (
  input  logic [N_ROADS-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               excl,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [MAX_ROADS-1:0] req_w;
  logic [3:0]           ptr_w;
  pick_t                pick;

  always_comb begin
    req_w = '0;
    req_w[N_ROADS-1:0] = req;
    ptr_w = '0;
    ptr_w[IW-1:0] = ptr;
    pick = rr_pick(req_w, ptr_w, excl, N_ROADS);
  end

  // Range guard keeps every index bit meaningful even when N_ROADS < 16.
  assign found = pick.found && ({1'b0, pick.idx} < 5'(N_ROADS));
  assign idx   = pick.idx[IW-1:0];

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-road controller: round-robin green slots, jam-priority slots bounded by min/max green,
// all-red clearance between slots and a starvation guard after a jam timeout.
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int N_ROADS       = 4,
  parameter int CNT_W         = 8,
  parameter int GREEN_CYC     = 20,
  parameter int MIN_GREEN_CYC = 5,
  parameter int JAM_GREEN_CYC = 40,
  parameter int CLEAR_CYC     = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  traffic_if.slave bus
);

  localparam int IW = $clog2(N_ROADS);

  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] J_LAST   = CNT_W'(JAM_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLEAR_CYC - 1);
  localparam logic [IW-1:0]    PTR_MAX  = IW'(N_ROADS - 1);

  if (JAM_GREEN_CYC > 2**CNT_W) begin : g_chk_cnt_w
    $error("JAM_GREEN_CYC does not fit in CNT_W");
  end
  if (MIN_GREEN_CYC > GREEN_CYC) begin : g_chk_min
    $error("MIN_GREEN_CYC exceeds GREEN_CYC");
  end
  if (N_ROADS < 2 || N_ROADS > MAX_ROADS) begin : g_chk_roads
    $error("N_ROADS out of range 2..16");
  end

  logic [1:0]         state;
  logic [IW-1:0]      ptr;
  logic [CNT_W-1:0]   cnt;
  logic               last_jam_timeout;

  logic [N_ROADS-1:0] ptr_oh;
  logic [IW-1:0]      ptr_inc;
  logic               other_jam;
  logic               cur_jam;
  logic               min_done;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;

  assign ptr_oh    = {{(N_ROADS-1){1'b0}}, 1'b1} << ptr;
  assign ptr_inc   = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
  assign other_jam = |(bus.traffic_jam & ~ptr_oh);
  assign cur_jam   = |(bus.traffic_jam & ptr_oh);
  assign min_done  = (cnt >= MIN_LAST);

  rr_jam_picker #(
    .N_ROADS (N_ROADS),
    .IW      (IW)
  ) u_picker (
    .req   (bus.traffic_jam),
    .ptr   (ptr),
    .excl  (last_jam_timeout),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= PTR_MAX;
      cnt              <= '0;
      last_jam_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.en) state <= CLEAR;
        end
        CLEAR: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (!bus.en) begin
              state <= IDLE;
            end else begin
              last_jam_timeout <= 1'b0;
              if (pick_found) begin
                ptr   <= pick_idx;
                state <= JAM_GREEN;
              end else begin
                ptr   <= ptr_inc;
                state <= GREEN;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GREEN: begin
          // A jam on our own road never extends or preempts a normal slot.
          if (cnt == G_LAST || (min_done && (other_jam || !bus.en))) begin
            state <= CLEAR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        JAM_GREEN: begin
          if (cnt == J_LAST) begin
            state            <= CLEAR;
            cnt              <= '0;
            last_jam_timeout <= cur_jam;
          end else if (min_done && (!cur_jam || !bus.en)) begin
            state <= CLEAR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.allow      = (state == GREEN || state == JAM_GREEN) ? ptr_oh : '0;
  assign bus.active_idx = ptr;
  assign bus.jam_mode   = (state == JAM_GREEN);
  assign bus.clearing   = (state == CLEAR);

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench: 4-road controller (G=4, MIN=2, JAM=6, CLR=1) plus a 3-road one-cycle-slot instance.
module tb_traffic_ctrl_nway;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traffic_if #(.N_ROADS(4)) bus ();
  traffic_if #(.N_ROADS(3)) bus3 ();

  traffic_ctrl_nway #(
    .N_ROADS(4), .CNT_W(8), .GREEN_CYC(4), .MIN_GREEN_CYC(2),
    .JAM_GREEN_CYC(6), .CLEAR_CYC(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  traffic_ctrl_nway #(
    .N_ROADS(3), .CNT_W(8), .GREEN_CYC(1), .MIN_GREEN_CYC(1),
    .JAM_GREEN_CYC(3), .CLEAR_CYC(1)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp3 [0:6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample n consecutive cycles expecting a fixed allow pattern and jam_mode.
  task automatic seq(input string tag, input logic [3:0] exp, input int n, input logic jm);
    repeat (n) begin
      @(negedge clk);
      chk(tag, 32'(bus.allow), 32'(exp));
      chk({tag, "_jm"}, 32'(bus.jam_mode), 32'(jm));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.traffic_jam = '0;
    bus3.en = 1'b0;
    bus3.traffic_jam = '0;
    exp3[0] = 3'b001; exp3[1] = 3'b000; exp3[2] = 3'b010; exp3[3] = 3'b000;
    exp3[4] = 3'b100; exp3[5] = 3'b000; exp3[6] = 3'b001;

    repeat (2) @(negedge clk);
    chk("rst_allow", 32'(bus.allow), 32'd0);
    chk("rst_idx", 32'(bus.active_idx), 32'd3);
    chk("rst_jm", 32'(bus.jam_mode), 32'd0);
    chk("rst_clr", 32'(bus.clearing), 32'd0);
    chk("rst_idx3", 32'(bus3.active_idx), 32'd2);

    // 1: plain round-robin
    rst_n = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("t1_clearing", 32'(bus.clearing), 32'd1);
    chk("t1_clr_allow", 32'(bus.allow), 32'd0);
    seq("t1_r0", 4'b0001, 4, 1'b0);
    seq("t1_c0", 4'b0000, 1, 1'b0);
    seq("t1_r1", 4'b0010, 4, 1'b0);
    seq("t1_c1", 4'b0000, 1, 1'b0);
    seq("t1_r2", 4'b0100, 4, 1'b0);
    seq("t1_c2", 4'b0000, 1, 1'b0);
    seq("t1_r3", 4'b1000, 4, 1'b0);
    seq("t1_c3", 4'b0000, 1, 1'b0);
    seq("t1_wrap", 4'b0001, 1, 1'b0);

    // 2: jam on road2 cuts road0 at MIN, then jam slot ends when jam drops
    bus.traffic_jam = 4'b0100;
    seq("t2_r0", 4'b0001, 1, 1'b0);
    seq("t2_clr", 4'b0000, 1, 1'b0);
    seq("t2_jam", 4'b0100, 3, 1'b1);
    bus.traffic_jam = 4'b0000;
    seq("t2_end", 4'b0000, 1, 1'b0);
    seq("t2_next", 4'b1000, 1, 1'b0);

    // 3: held jam times out, guard serves next road, then jam returns
    bus.traffic_jam = 4'b0100;
    seq("t3_r3", 4'b1000, 1, 1'b0);
    seq("t3_clr0", 4'b0000, 1, 1'b0);
    seq("t3_jam", 4'b0100, 6, 1'b1);
    seq("t3_clr1", 4'b0000, 1, 1'b0);
    seq("t3_guard", 4'b1000, 2, 1'b0);
    chk("t3_guard_idx", 32'(bus.active_idx), 32'd3);
    seq("t3_clr2", 4'b0000, 1, 1'b0);
    seq("t3_rejam", 4'b0100, 1, 1'b1);

    // 4: simultaneous jams on 1 and 3 resolved round-robin from ptr=0
    bus.traffic_jam = 4'b0000;
    seq("t4_jam_min", 4'b0100, 1, 1'b1);
    seq("t4_c0", 4'b0000, 1, 1'b0);
    seq("t4_r3", 4'b1000, 4, 1'b0);
    seq("t4_c1", 4'b0000, 1, 1'b0);
    seq("t4_r0", 4'b0001, 4, 1'b0);
    bus.traffic_jam = 4'b1010;
    seq("t4_c2", 4'b0000, 1, 1'b0);
    seq("t4_j1", 4'b0010, 6, 1'b1);
    seq("t4_c3", 4'b0000, 1, 1'b0);
    seq("t4_j3", 4'b1000, 6, 1'b1);
    seq("t4_c4", 4'b0000, 1, 1'b0);
    seq("t4_j1b", 4'b0010, 1, 1'b1);
    bus.traffic_jam = 4'b0000;
    seq("t4_j1_min", 4'b0010, 1, 1'b1);
    seq("t4_c5", 4'b0000, 1, 1'b0);
    seq("t4_r2", 4'b0100, 1, 1'b0);

    // 5: en drop honours MIN then parks in IDLE; async reset mid jam slot
    bus.en = 1'b0;
    seq("t5_min", 4'b0100, 1, 1'b0);
    @(negedge clk);
    chk("t5_clearing", 32'(bus.clearing), 32'd1);
    chk("t5_clr_allow", 32'(bus.allow), 32'd0);
    @(negedge clk);
    chk("t5_idle_clr", 32'(bus.clearing), 32'd0);
    chk("t5_idle_allow", 32'(bus.allow), 32'd0);
    chk("t5_idle_idx", 32'(bus.active_idx), 32'd2);
    @(negedge clk);
    chk("t5_idle_hold", 32'(bus.allow), 32'd0);
    bus.traffic_jam = 4'b0001;
    bus.en = 1'b1;
    @(negedge clk);
    chk("t5_restart_clr", 32'(bus.clearing), 32'd1);
    seq("t5_jam0", 4'b0001, 1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_allow", 32'(bus.allow), 32'd0);
    chk("t5_rst_idx", 32'(bus.active_idx), 32'd3);
    chk("t5_rst_jm", 32'(bus.jam_mode), 32'd0);

    // 6: three roads, one-cycle slots
    bus.en = 1'b0;
    bus.traffic_jam = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus3.en = 1'b1;
    @(negedge clk);
    chk("t6_clearing", 32'(bus3.clearing), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("t6_allow%0d", i), 32'(bus3.allow), 32'(exp3[i]));
      chk($sformatf("t6_onehot%0d", i), 32'($onehot0(bus3.allow)), 32'd1);
    end
    chk("t6_dut4_idle", 32'(bus.allow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
